// File: rtl/alu_pkg.sv
// Shared types for the ALU result path: the flag bundle that travels with each
// result and the bit positions of each flag inside it.
package alu_pkg;

   typedef struct packed {
      logic c;
      logic v;
      logic n;
      logic z;
   } alu_flags_t;

   localparam int FLAG_C = 3;
   localparam int FLAG_V = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;

endpackage

// File: rtl/alu_rb_mem.sv
// Storage array for the result buffer: synchronous write, asynchronous read.
// There is no reset, because the top masks the read data whenever the buffer is empty.
module alu_rb_mem #(
   parameter int WIDTH = 7,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // write the enqueued entry into its slot
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_result_buffer.sv
// ALU result buffer: queues {y, c, v, n, z} entries between the ALU and the
// register-file writeback over a valid/ready handshake.
// Optional feature: define ALU_RB_STICKY_EN to accumulate popped flags in 'sticky'.
module alu_result_buffer
   import alu_pkg::*;
#(
   parameter int w     = 3,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [w-1:0]             in_y,
   input  logic                     in_c_out,
   input  logic                     in_v,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [w-1:0]             out_y,
   output logic [3:0]               out_flags,
   output logic [$clog2(DEPTH):0]   count,
   output logic [3:0]               sticky,
   input  logic                     sticky_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = w + 4;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;
   alu_flags_t    in_flags;
   alu_flags_t    head_flags;
   logic [w-1:0]  head_y;
   logic [EW-1:0] rd_data;

   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign count     = count_q;

   // n and z are derived here so that the flags stored with an entry always match its y
   always_comb begin
      in_flags   = '0;
      in_flags.c = in_c_out;
      in_flags.v = in_v;
      in_flags.n = in_y[w-1];
      in_flags.z = (in_y == '0);
   end

   alu_rb_mem #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i ({in_y, in_flags}),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data)
   );

   assign head_y     = rd_data[EW-1:4];
   assign head_flags = rd_data[3:0];

   // an empty buffer drives zeros instead of whatever is left in the array
   assign out_y     = out_valid ? head_y : '0;
   assign out_flags = out_valid ? head_flags : '0;

   // pointer and occupancy next state; pointers wrap because DEPTH is a power of two
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // pointer and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

`ifdef ALU_RB_STICKY_EN
   logic [3:0] sticky_q, sticky_d;

   // a clear on the same edge as a pop keeps only the popped entry's flags
   always_comb begin
      sticky_d = sticky_q;
      if (sticky_clr) sticky_d = '0;
      if (pop)        sticky_d = sticky_d | head_flags;
   end

   // sticky flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sticky_q <= '0;
      else        sticky_q <= sticky_d;
   end

   assign sticky = sticky_q;
`else
   logic unused_sticky_clr;
   assign unused_sticky_clr = sticky_clr;
   assign sticky            = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer (w=3, DEPTH=4). Builds with or without
// ALU_RB_STICKY_EN; sticky expectations follow the same macro.
module tb_alu_result_buffer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready;
   logic [2:0] in_y;
   logic       in_c_out, in_v;
   logic       out_valid, out_ready;
   logic [2:0] out_y;
   logic [3:0] out_flags;
   logic [2:0] count;
   logic [3:0] sticky;
   logic       sticky_clr;

   int checks = 0;
   int errors = 0;

   // reference queue of {y, c, v, n, z}
   logic [6:0] mq[$];
   logic [3:0] st_m = 4'b0000;

   alu_result_buffer #(.w(3), .DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_y       (in_y),
      .in_c_out   (in_c_out),
      .in_v       (in_v),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_y      (out_y),
      .out_flags  (out_flags),
      .count      (count),
      .sticky     (sticky),
      .sticky_clr (sticky_clr)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] mk_flags(logic [2:0] y, logic c, logic v);
      return {c, v, y[2], (y == 3'd0)};
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      chk("count",     32'(count),     32'(mq.size()));
      chk("in_ready",  32'(in_ready),  32'(mq.size() != 4));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("out_y",     32'(out_y),     (mq.size() != 0) ? 32'(mq[0][6:4]) : 32'd0);
      chk("out_flags", 32'(out_flags), (mq.size() != 0) ? 32'(mq[0][3:0]) : 32'd0);
      chk("sticky",    32'(sticky),    32'(st_m));
   endtask

   // one clock edge with the current inputs, then update the model and compare
   task automatic tick();
      bit         push, pop;
      logic [3:0] hf;
      push = in_valid && (mq.size() != 4);
      pop  = out_ready && (mq.size() != 0);
      hf   = pop ? mq[0][3:0] : 4'b0000;
      @(posedge clk);
      #1;
      if (pop) mq.delete(0);
      if (push) mq.push_back({in_y, mk_flags(in_y, in_c_out, in_v)});
`ifdef ALU_RB_STICKY_EN
      if (sticky_clr) st_m = 4'b0000;
      if (pop)        st_m = st_m | hf;
`endif
      check_state();
   endtask

   initial begin
      logic [2:0] pop_order [8];
      logic [2:0] drain_order [3];
      logic [2:0] src;
      bit         acc;
      pop_order   = '{3'd4, 3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3};
      drain_order = '{3'd4, 3'd5, 3'd6};

      rst_n = 1'b0; in_valid = 1'b0; in_y = 3'd0; in_c_out = 1'b0; in_v = 1'b0;
      out_ready = 1'b0; sticky_clr = 1'b0;
      #12;
      check_state();
      @(negedge clk) rst_n = 1'b1;

      // first push: y=4, c=0, v=1 -> flags {c,v,n,z} = 0110
      in_valid = 1'b1; in_y = 3'd4; in_c_out = 1'b0; in_v = 1'b1;
      tick();
      chk("t2_out_y", 32'(out_y), 32'd4);
      chk("t2_out_flags", 32'(out_flags), 32'b0110);

      // fill the buffer, then a fifth push must be refused
      in_y = 3'd0; in_c_out = 1'b0; in_v = 1'b0; tick();
      in_y = 3'd1; in_c_out = 1'b1; tick();
      in_y = 3'd2; in_c_out = 1'b0; tick();
      chk("t3_full_ready", 32'(in_ready), 32'd0);
      in_y = 3'd7; tick();
      chk("t3_refused_count", 32'(count), 32'd4);
      chk("t3_head_kept", 32'(out_y), 32'd4);

      // streaming from full with a source that holds while in_ready is low
      out_ready = 1'b1; in_valid = 1'b1; in_c_out = 1'b0; in_v = 1'b0; src = 3'd0;
      for (int i = 0; i < 8; i++) begin
         in_y = src;
         chk("t4_pop_order", 32'(out_y), 32'(pop_order[i]));
         acc = (mq.size() != 4);
         tick();
         if (acc) src = src + 3'd1;
         if (i == 0) chk("t4_zero_flags", 32'(out_flags), 32'b0001);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t4_drain_order", 32'(out_y), 32'(drain_order[i]));
         tick();
      end
      chk("t4_empty_y", 32'(out_y), 32'd0);

      // two entries, then push and pop on the same edge
      out_ready = 1'b0; in_valid = 1'b1;
      in_y = 3'd3; in_c_out = 1'b0; in_v = 1'b0; tick();
      in_y = 3'd6; in_c_out = 1'b1; in_v = 1'b1; tick();
      in_y = 3'd5; in_c_out = 1'b0; in_v = 1'b0; out_ready = 1'b1; tick();
      chk("t5_count", 32'(count), 32'd2);
      chk("t5_head_y", 32'(out_y), 32'd6);
      chk("t5_head_flags", 32'(out_flags), 32'b1110);

      // asynchronous reset in the middle of a cycle with three entries queued
      out_ready = 1'b0; in_y = 3'd1; tick();
      chk("t1_pre_count", 32'(count), 32'd3);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      mq.delete();
      st_m = 4'b0000;
      chk("t1_count", 32'(count), 32'd0);
      chk("t1_out_valid", 32'(out_valid), 32'd0);
      chk("t1_in_ready", 32'(in_ready), 32'd1);
      chk("t1_out_y", 32'(out_y), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // sticky accumulation: pop c=1 entry then v=1 entry
      in_valid = 1'b1; in_y = 3'd1; in_c_out = 1'b1; in_v = 1'b0; tick();
      in_c_out = 1'b0; in_v = 1'b1; tick();
      in_valid = 1'b0; out_ready = 1'b1; tick(); tick();
`ifdef ALU_RB_STICKY_EN
      chk("t6_sticky_acc", 32'(sticky), 32'b1100);
`else
      chk("t6_sticky_off", 32'(sticky), 32'b0000);
`endif
      out_ready = 1'b0; sticky_clr = 1'b1; tick();
      sticky_clr = 1'b0;
      chk("t6_sticky_clr", 32'(sticky), 32'b0000);

      // clear on the same edge as a pop keeps only that entry's flags
      in_valid = 1'b1; in_y = 3'd0; in_c_out = 1'b0; in_v = 1'b0; tick();
      in_y = 3'd4; in_c_out = 1'b1; in_v = 1'b1; tick();
      in_valid = 1'b0; out_ready = 1'b1; tick();
      sticky_clr = 1'b1; tick();
      sticky_clr = 1'b0; out_ready = 1'b0;
`ifdef ALU_RB_STICKY_EN
      chk("t6_clr_pop", 32'(sticky), 32'b1110);
`else
      chk("t6_clr_pop_off", 32'(sticky), 32'b0000);
`endif
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
